// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud divider helper.
package uart_pkg;

  // One-hot receiver states; any other encoding is treated as IDLE.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_START = 4'b0010,
    ST_DATA  = 4'b0100,
    ST_STOP  = 4'b1000
  } uart_rx_state_t;

  // Clocks per oversample tick, floored and never below 1.
  function automatic int uart_div(input int clk_freq, input int baud_rate,
                                  input int oversample);
    int d;
    d = clk_freq / (baud_rate * oversample);
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Consumer-side bundle of the UART receiver.
//
// Handshake: the receiver raises rx_valid with rx_data and holds both stable
// until the consumer has rx_ready high at a clock edge where rx_valid is high;
// that edge is the transfer. rx_ready may be high or low at any time and does
// not depend on rx_valid. frame_err / overrun_err are single-cycle pulses and
// are not part of the handshake.
interface uart_rx_if #(
  parameter int DW = 8
);
  import uart_pkg::*;

  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          rx_busy;
  logic          frame_err;
  logic          overrun_err;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_busy,
    output frame_err,
    output overrun_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  rx_busy,
    input  frame_err,
    input  overrun_err,
    output rx_ready
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-cycle tick every DIV enabled clocks.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Tick only while enabled so a DIV of 1 stays quiet when idle.
  assign tick = en && !clr && (cnt == LAST);

  // Counter sits at 0 while disabled or cleared and wraps after LAST.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, DW data bits LSB-first, 1 stop, no parity.
// Oversampled line, decisions taken at the middle of each bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DW         = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           rx,
  uart_rx_if.master      bus,
  output uart_rx_state_t state_dbg
);

  localparam int DIV = uart_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DW + 1);

  localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMP_FULL = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DW - 1);

  uart_rx_state_t state, state_next;

  logic          rx_meta, rx_s, rx_d;
  logic          fall;
  logic          tick;
  logic [SW-1:0] samp_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DW-1:0] shreg;

  logic start_go, samp_clr, samp_inc, shift_en, stop_done;

  logic [DW-1:0] rx_data_q;
  logic          rx_valid_q;
  logic          frame_err_q;
  logic          overrun_err_q;

  // Two-flop synchronizer plus one delay flop for falling-edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  assign fall = rx_d && !rx_s;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en    (state != ST_IDLE),
    .clr   (start_go),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state and per-cycle strobes for the counters and output stage.
  always_comb begin
    state_next = state;
    start_go   = 1'b0;
    samp_clr   = 1'b0;
    samp_inc   = 1'b0;
    shift_en   = 1'b0;
    stop_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fall) begin
          state_next = ST_START;
          start_go   = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          if (samp_cnt == SAMP_MID) begin
            samp_clr   = 1'b1;
            // A line back high at mid start bit was a glitch.
            state_next = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            samp_inc = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (samp_cnt == SAMP_FULL) begin
            samp_clr = 1'b1;
            shift_en = 1'b1;
            if (bit_cnt == BIT_LAST) state_next = ST_STOP;
          end else begin
            samp_inc = 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (samp_cnt == SAMP_FULL) begin
            // Leave at mid stop bit so the next start edge is not missed.
            samp_clr   = 1'b1;
            stop_done  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            samp_inc = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Sample/bit counters and the LSB-first shift register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      samp_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else if (start_go) begin
      samp_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (samp_clr)      samp_cnt <= '0;
      else if (samp_inc) samp_cnt <= samp_cnt + SW'(1);
      if (shift_en) begin
        shreg   <= {rx_s, shreg[DW-1:1]};
        bit_cnt <= bit_cnt + BW'(1);
      end
    end
  end

  // Output holding register, handshake and error pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      if (rx_valid_q && bus.rx_ready) rx_valid_q <= 1'b0;
      if (stop_done) begin
        if (rx_s) begin
          if (!rx_valid_q || bus.rx_ready) begin
            rx_data_q  <= shreg;
            rx_valid_q <= 1'b1;
          end else begin
            overrun_err_q <= 1'b1;
          end
        end else begin
          frame_err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_busy     = (state != ST_IDLE);
  assign bus.frame_err   = frame_err_q;
  assign bus.overrun_err = overrun_err_q;
  assign state_dbg       = state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 32 clocks per bit (DIV=2, OVERSAMPLE=16).
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BIT_CLKS = 32;
  localparam int LAT      = 306;   // 2 + (8 + 16*9) * 2
  localparam int W        = 42;    // {kind[1:0], data[7:0], cycle[31:0]}

  localparam logic [1:0] K_DATA  = 2'd0;
  localparam logic [1:0] K_FRAME = 2'd1;
  localparam logic [1:0] K_OVR   = 2'd2;

  logic clk;
  logic rst_i;
  logic rx;
  uart_rx_state_t state_dbg;
  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];

  uart_rx_if #(.DW(8)) bus ();

  uart_rx #(
    .CLK_FREQ   (3_200_000),
    .BAUD_RATE  (100_000),
    .DW         (8),
    .OVERSAMPLE (16)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .rx        (rx),
    .bus       (bus.master),
    .state_dbg (state_dbg)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; queues the expected event at E + LAT.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic [1:0] kind, input logic [7:0] exp_d,
                            input bit chk_busy);
    int e;
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    e = cyc + 1;
    exp_q.push_back({kind, exp_d, 32'(e + LAT)});
    for (int b = 0; b < 10; b++) begin
      rx = bits[b];
      for (int k = 0; k < BIT_CLKS; k++) begin
        wait_cyc(1);
        if (chk_busy && b == 0 && k == 1) check("busy_before_start", bus.rx_busy, 0);
        if (chk_busy && b == 0 && k == 2) check("busy_at_start", bus.rx_busy, 1);
      end
    end
    rx = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every new valid or error pulse.
  logic prev_v = 1'b0;
  logic prev_r = 1'b0;
  always @(negedge clk) begin : mon
    logic new_v;
    logic [1:0] k;
    logic [W-1:0] e;
    new_v = bus.rx_valid && (!prev_v || prev_r);
    if (bus.frame_err && bus.overrun_err) begin
      n_checks++;
      n_errors++;
      $display("FAIL err_exclusive: both error pulses high at cycle %0d, required at most one", cyc);
    end
    if (new_v || bus.frame_err || bus.overrun_err) begin
      k = new_v ? K_DATA : (bus.frame_err ? K_FRAME : K_OVR);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_event: kind %0d data %0h at cycle %0d, required none",
                 k, bus.rx_data, cyc);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", 32'(k), 32'(e[41:40]));
        check("event_cycle", 32'(cyc), e[31:0]);
        if (k != K_FRAME) check("event_data", 32'(bus.rx_data), 32'(e[39:32]));
      end
    end
    prev_v = bus.rx_valid;
    prev_r = bus.rx_ready;
  end

  // Directed sequence.
  initial begin
    rst_i = 1'b1;
    rx = 1'b1;
    bus.rx_ready = 1'b1;
    wait_cyc(3);
    check("rst_busy", bus.rx_busy, 0);
    check("rst_valid", bus.rx_valid, 0);
    check("rst_data", 32'(bus.rx_data), 0);
    check("rst_frame_err", bus.frame_err, 0);
    check("rst_overrun_err", bus.overrun_err, 0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    rst_i = 1'b0;
    wait_cyc(5);

    // Loopback 0xA5.
    send_frame(8'hA5, 1'b1, K_DATA, 8'hA5, 1'b1);
    check("a5_data_held", 32'(bus.rx_data), 32'h A5);
    check("a5_valid_cleared", bus.rx_valid, 0);

    // Back-to-back 0x00 then 0xFF.
    send_frame(8'h00, 1'b1, K_DATA, 8'h00, 1'b0);
    check("b2b_busy_gap", bus.rx_busy, 0);
    send_frame(8'hFF, 1'b1, K_DATA, 8'hFF, 1'b0);
    wait_cyc(10);

    // Glitch: 10 clocks low.
    rx = 1'b0;
    wait_cyc(6);
    check("glitch_busy", bus.rx_busy, 1);
    wait_cyc(4);
    rx = 1'b1;
    wait_cyc(60);
    check("glitch_idle", bus.rx_busy, 0);
    check("glitch_no_valid", bus.rx_valid, 0);

    // Framing error on 0x3C, then good 0x11.
    send_frame(8'h3C, 1'b0, K_FRAME, 8'h00, 1'b0);
    check("frame_no_valid", bus.rx_valid, 0);
    wait_cyc(40);
    send_frame(8'h11, 1'b1, K_DATA, 8'h11, 1'b0);
    wait_cyc(10);

    // Overrun: 0x12 held, 0x34 dropped.
    bus.rx_ready = 1'b0;
    send_frame(8'h12, 1'b1, K_DATA, 8'h12, 1'b0);
    send_frame(8'h34, 1'b1, K_OVR, 8'h12, 1'b0);
    check("ovr_valid_held", bus.rx_valid, 1);
    check("ovr_data_held", 32'(bus.rx_data), 32'h12);
    bus.rx_ready = 1'b1;
    wait_cyc(1);
    check("ovr_valid_cleared", bus.rx_valid, 0);
    wait_cyc(10);

    // Reset in the middle of DATA, then 0x5A.
    rx = 1'b0;
    wait_cyc(BIT_CLKS);
    rx = 1'b1;
    wait_cyc(40);
    check("mid_state_data", 32'(state_dbg), 32'(ST_DATA));
    rst_i = 1'b1;
    wait_cyc(1);
    rst_i = 1'b0;
    check("midrst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("midrst_busy", bus.rx_busy, 0);
    check("midrst_valid", bus.rx_valid, 0);
    check("midrst_data", 32'(bus.rx_data), 0);
    check("midrst_errs", {bus.frame_err, bus.overrun_err}, 0);
    wait_cyc(300);
    send_frame(8'h5A, 1'b1, K_DATA, 8'h5A, 1'b0);
    wait_cyc(20);

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: recovers DW-bit frames (1 start, DW data LSB-first, 1 stop, no parity) from the serial line driven by `uart_tx`, using an oversampled, mid-bit sampling FSM. It sits directly downstream of the line and feeds a valid/ready consumer. It flags framing errors and overruns. Frame format and baud parameters match `uart_tx`, so the two loop back directly.

## Interface
- `CLK_FREQ`, default 100_000_000: clock frequency in Hz.
- `BAUD_RATE`, default 115200: line rate.
- `DW`, default 8: data bits per frame.
- `OVERSAMPLE`, default 16: ticks per bit; must be even and ≥4.
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `rx` in 1: serial line, asynchronous, idles high.
- `rx_data` out DW: received byte; stable while `rx_valid`=1.
- `rx_valid` out 1: data available; held until accepted.
- `rx_ready` in 1: consumer accepts when `rx_valid && rx_ready`.
- `rx_busy` out 1: frame in progress (state != IDLE).
- `frame_err` out 1: one-cycle pulse; stop bit sampled low.
- `overrun_err` out 1: one-cycle pulse; good frame dropped because the previous one was unaccepted.

## Operation
- Synchronizer: `rx` passes through 2 flops (reset value 1), then one delay flop for edge detection. All logic uses the synchronized value `rx_s`.
- Tick divider: `DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE)` (integer division, ≥1). Counter width is `$clog2(DIV)`, minimum 1.
  - Counter is held at 0 in IDLE and cleared on entry to START.
  - `tick` = counter == DIV-1, then the counter wraps to 0.
- Sample counter: `$clog2(OVERSAMPLE)` bits, counts ticks. Bit counter: `$clog2(DW+1)` bits.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a falling edge of `rx_s` (previous 1, current 0), go to START and clear the counters. A line held low never retriggers.
  - START: on the tick where the sample count reaches OVERSAMPLE/2-1 (mid start bit):
    - `rx_s`=0: go to DATA and clear the sample counter.
    - `rx_s`=1: glitch; return to IDLE with no flag.
  - DATA: every OVERSAMPLE ticks (mid-bit), shift `rx_s` into the MSB of the shift register (right shift, LSB-first). After the DW-th sample, go to STOP.
  - STOP: after OVERSAMPLE ticks (mid stop bit), always go to IDLE. This early return allows resync on the next start edge.
    - `rx_s`=1 and (`!rx_valid` or `rx_ready`): load `rx_data` and set `rx_valid`.
    - `rx_s`=1 and `rx_valid && !rx_ready`: keep the old data and pulse `overrun_err`.
    - `rx_s`=0: pulse `frame_err`; discard data; `rx_valid` is unchanged.
- `rx_valid` clears on the cycle after `rx_valid && rx_ready`, unless a new frame loads in that same cycle (then it stays 1 with the new data).
- Undefined state encodings go to IDLE.

## Timing
- Reset values: state IDLE, `rx_valid`=0, `rx_data`=0, `rx_busy`=0, `frame_err`=0, `overrun_err`=0, synchronizer flops =1.
- Reset mid-frame: the next cycle is IDLE with all outputs at reset values; the partial frame is lost.
- Let edge E be the first clock edge at which `rx` is sampled low.
  - State is START (and `rx_busy`=1) from edge E+2.
  - `rx_valid`/error pulse and return to IDLE occur at edge E+2+(OVERSAMPLE/2+OVERSAMPLE·(DW+1))·DIV.
  - For defaults: DIV=54, giving E+2+8208. Baud mismatch against `uart_tx` is 0.46%, which is tolerated.
- Glitch rejection: a low pulse shorter than (OVERSAMPLE/2)·DIV clocks returns to IDLE with no output.
- `frame_err` and `overrun_err` are never asserted in the same cycle.

## Structure
- `uart_pkg`: `uart_rx_state_t` enum (one-hot, 4 bits, matching the tx encoding style) and a `uart_div` function computing DIV. This package is shared with `uart_tx`.
- Sub-module `uart_baud_tick`: parameterized tick divider with `en`/`clr` inputs and a `tick` output. It is reusable by tx.
- The synchronizer and FSM stay inline.

## Test plan
Bench parameters: CLK_FREQ=3_200_000, BAUD_RATE=100_000, DW=8, OVERSAMPLE=16, giving DIV=2 (32 clk/bit).
- Loopback: `uart_tx` sends 0xA5 with `rx_ready`=1 → `rx_valid` for 1 cycle with `rx_data`=0xA5 exactly 306 clocks after E; no error pulses.
- Back-to-back: tx sends 0x00 then 0xFF, `rx_ready`=1 → two valids, data 0x00 then 0xFF, `rx_busy` drops between the frames.
- Glitch: `rx` low for 10 clocks → `rx_busy` pulses, no `rx_valid`, no errors.
- Framing: hand-driven frame 0x3C with stop bit 0 → `frame_err` pulse, `rx_valid` stays 0; a following good frame 0x11 is received.
- Overrun: frames 0x12 then 0x34 with `rx_ready`=0 → `rx_data`=0x12 held, `overrun_err` pulse at the second frame; raising `rx_ready` clears `rx_valid`.
- Reset: assert `rst_i` mid-DATA for 1 cycle → IDLE with all outputs at reset values; the next frame 0x5A is received correctly.
